// File: rtl/imem_boot_loader.sv
// Boot loader: framed byte stream -> little-endian 32-bit Imem word writes; holds core in reset until loaded.
// Optional trailing XOR checksum byte enabled by macro LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] len_n;
  logic [1:0]       idx_q, idx_d;
  logic [23:0]      word_q, word_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    busy       = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CHECK);
    byte_ready = busy && !we_q;
    accept     = byte_valid && byte_ready;
    len_n      = CNT_W'({byte_data, len_q[7:0]});

    // Counter advances in the write cycle; no byte can be accepted then.
    if (we_q) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = CNT_W'(byte_data);
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_n;
          if (len_n > MAX_N)       state_d = S_ERR;
          else if (len_n == '0)    state_d = S_TAIL;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {byte_data, word_q[23:8]};
          idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = 32'({cnt_q, 2'b00});
            wdata_d = {byte_data, word_q};
            if (cnt_q == len_q - 1'b1) state_d = S_TAIL;
          end
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) state_d = (byte_data == chk_q) ? S_DONE : S_ERR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_rst   = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: expected Imem writes queued at stimulus time, checked by a write monitor.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, core_rst, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;

  always #5 clk = ~clk;

  imem_boot_loader #(.MAX_WORDS(256), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int we_base = 0;
  wr_t exp_q[$];
  logic [31:0] prog [2] = '{32'h00500513, 32'h00a00593};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_t e;
      we_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte %h not accepted within 40 cycles", b);
    end
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Two-word program frame; chk_flip corrupts the checksum byte when nonzero.
  task automatic load(input int gap, input logic [7:0] chk_flip);
    logic [7:0] x = 8'h00;
    logic [7:0] bb;
    pulse_start();
    send_byte(8'h02, gap);
    send_byte(8'h00, gap);
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back('{addr: 32'(w * 4), data: prog[w]});
      for (int b = 0; b < 4; b++) begin
        bb = prog[w][8*b +: 8];
        x  = x ^ bb;
        send_byte(bb, (b == 3) ? 0 : gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ chk_flip, 0);
`else
    if (chk_flip != 8'h00) x = x ^ chk_flip;
`endif
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_imem_we"},    imem_we, 0);
    check({tag, "_imem_addr"},  imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst"},   core_rst, 1);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_error"},      error, 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    #10;
    @(negedge clk) rst = 1'b0;

    // Good two-word image
    we_base = we_cnt;
    load(0, 8'h00);
    check("c1_done", done, 1);
    check("c1_error", error, 0);
    check("c1_core_rst", core_rst, 0);
    check("c1_we_pulses", we_cnt - we_base, 2);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum: writes still happen, then error
    we_base = we_cnt;
    load(0, 8'h01);
    check("c2_error", error, 1);
    check("c2_done", done, 0);
    check("c2_core_rst", core_rst, 1);
    check("c2_we_pulses", we_cnt - we_base, 2);
`endif

    // Empty image
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("c3_done", done, 1);
    check("c3_error", error, 0);
    check("c3_we_pulses", we_cnt - we_base, 0);

    // Oversized image N=257
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("c4_error", error, 1);
    check("c4_byte_ready", byte_ready, 0);
    check("c4_busy", busy, 0);
    check("c4_core_rst", core_rst, 1);
    repeat (3) @(posedge clk);
    #1;
    check("c4_we_pulses", we_cnt - we_base, 0);

    // Stalled stream, valid held high across the write cycle
    we_base = we_cnt;
    load(3, 8'h00);
    check("c5_done", done, 1);
    check("c5_we_pulses", we_cnt - we_base, 2);

    // Async reset mid-load after the 6th byte, then full reload
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    exp_q.push_back('{addr: 32'h0, data: prog[0]});
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("c6_rst");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("c6_idle_busy", busy, 0);
    check("c6_idle_core_rst", core_rst, 1);
    load(0, 8'h00);
    check("c6_done", done, 1);
    check("c6_core_rst", core_rst, 0);
    check("c6_we_pulses", we_cnt - we_base, 3);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
